// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared widths, image constants and write-buffer entry type
package acc_pkg;

    localparam int ADDR_W            = 16;
    localparam int WORD_W            = 32;
    localparam int IMG_WORDS_PER_ROW = 88;
    localparam int OUT_BASE          = 25344;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/mem_port_sched_if.sv
// rtl/mem_port_sched_if.sv - requester and memory-side signals of the port scheduler
interface mem_port_sched_if;
    import acc_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_gnt;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] dataR;
    logic [WORD_W-1:0] dataW;
    logic              en;
    logic              we;
    logic              busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, dataR,
        output rd_gnt, rd_valid, rd_data, wr_gnt, addr, dataW, en, we, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, dataR,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, addr, dataW, en, we, busy
    );

endinterface

// File: rtl/mem_port_sched_wbuf_fifo.sv
// rtl/mem_port_sched_wbuf_fifo.sv - write-buffer FIFO; DEPTH must be a power of two >= 2
module wbuf_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  wbuf_entry_t din,
    output logic        full,
    output logic        empty,
    output wbuf_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - single-port memory scheduler: reads vs buffered writes with read-streak cap
module mem_port_sched
    import acc_pkg::*;
#(
    parameter int RD_STREAK_MAX = 4,
    parameter int WBUF_DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_sched_if.slave    bus
);

    localparam int STREAK_W = $clog2(RD_STREAK_MAX + 1);

    logic                wb_full, wb_empty, wb_push, wb_pop;
    wbuf_entry_t         wb_head, wb_din;
    logic                rd_sel, wr_sel;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                rd_valid_q;

    assign wb_din  = '{addr: bus.wr_addr, data: bus.wr_data};
    assign wb_push = bus.wr_gnt;
    assign wb_pop  = wr_sel;

    wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   (wb_din),
        .full  (wb_full),
        .empty (wb_empty),
        .head  (wb_head)
    );

    // Decisions use the registered empty flag, so a word pushed this cycle waits a cycle.
    always_comb begin
        rd_sel = 1'b0;
        wr_sel = 1'b0;
        if (!reset) begin
            if (wb_empty) begin
                rd_sel = bus.rd_req;
            end else if (wb_full) begin
                wr_sel = 1'b1;
            end else if (bus.rd_req && (streak_q < STREAK_W'(RD_STREAK_MAX))) begin
                rd_sel = 1'b1;
            end else begin
                wr_sel = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (wr_sel || wb_empty) begin
            streak_d = '0;
        end else if (rd_sel && (streak_q < STREAK_W'(RD_STREAK_MAX))) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            streak_q   <= streak_d;
            rd_valid_q <= rd_sel;
        end
    end

    assign bus.wr_gnt   = !reset && bus.wr_req && !wb_full;
    assign bus.rd_gnt   = rd_sel;
    assign bus.en       = rd_sel || wr_sel;
    assign bus.we       = wr_sel;
    assign bus.addr     = rd_sel ? bus.rd_addr : (wr_sel ? wb_head.addr : '0);
    assign bus.dataW    = wr_sel ? wb_head.data : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bus.dataR;
    assign bus.busy     = !wb_empty || rd_valid_q;

endmodule
